contador_updown_param: RTL
==========================

# contador_updown_param

Parametrised up/down counter, successor to the fixed 8-bit up/down counter. Adds configurable width, a runtime count limit, wrap or saturate mode, synchronous parallel load and count enable. Also produces a terminal-count pulse and a sticky overflow flag. Used wherever the design needs a bounded event or position counter that reports boundary crossings.

## Interface
- WIDTH, 8, counter width in bits (2..32)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low; rst=0 forces all outputs to reset values immediately
- en  in  1  count enable; one step per rising edge while en=1
- ud  in  1  direction; 1 = count up, 0 = count down
- load  in  1  synchronous parallel load
- din  in  WIDTH  load value
- limit  in  WIDTH  upper bound; legal count range is 0..limit inclusive
- sat  in  1  boundary mode; 1 = saturate, 0 = wrap
- clr_ovf  in  1  synchronous clear of ovf
- cont  out  WIDTH  current count
- tc  out  1  terminal-count pulse, high for one cycle per boundary event
- ovf  out  1  sticky flag, set by any boundary event

## Operation
- Reset (rst=0): cont=0, tc=0, ovf=0. Held for as long as rst=0, regardless of clk. Reset takes priority over every other input.
- Per-edge priority: load > en > hold.
- Load (load=1): cont <= din if din <= limit, else cont <= limit. tc <= 0. A load is never a boundary event. en and ud are ignored that cycle.
- Hold (load=0, en=0): cont unchanged, tc <= 0.
- Count up (en=1, ud=1):
  - cont < limit: cont <= cont+1, no event.
  - cont >= limit: boundary event. With sat=0, cont <= 0. With sat=1, cont <= limit.
- Count down (en=1, ud=0):
  - 0 < cont <= limit: cont <= cont-1, no event.
  - cont == 0: boundary event. With sat=0, cont <= limit. With sat=1, cont stays 0.
  - cont > limit (limit lowered at runtime): cont <= limit, no event.
- Boundary event: tc <= 1 for exactly that edge, otherwise tc <= 0. ovf <= 1.
- ovf clear:
  - clr_ovf=1 with no event that edge: ovf <= 0.
  - Event and clr_ovf=1 on the same edge: the set wins, so ovf=1.
- limit=0: the count stays 0. Every enabled step is a boundary event in either direction and either mode.
- Arithmetic is unsigned modulo 2^WIDTH. The limit checks ensure cont never leaves 0..limit after any counting step.
- limit and sat are sampled every edge. Changing them mid-count takes effect on the next step, with no extra latency.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency is 1 cycle: inputs sampled at edge N appear on cont, tc and ovf after edge N.
- tc is high in the same cycle that cont shows the post-boundary value.
- Back-to-back boundary events (e.g. limit=0, en held high) keep tc high continuously, one event per cycle.
- Reset assertion is asynchronous. Reset release is synchronised by the integration level; the block needs no internal synchroniser. The first count step occurs on the first rising edge with rst=1.
- rst asserted mid-count clears cont, tc and ovf without waiting for an edge.

## Test plan
- Wrap up: WIDTH=8, limit=5, sat=0, ud=1, en=1 from reset for 7 edges -> cont 1,2,3,4,5,0,1. tc=1 only in the cycle cont=0. ovf=1 from then on.
- Saturate down: limit=200, sat=1, load din=2 then ud=0, en=1 for 4 edges -> cont 2,1,0,0,0. tc=1 in each of the last two cycles. ovf=1.
- Load clamp and priority: limit=100. Load din=150 with en=1 -> cont=100, tc=0. Next edge with en=1, ud=1, sat=0 -> cont=0, tc=1.
- Limit lowered: cont=50, then limit set to 10. One step down -> cont=10, tc=0. One step up with sat=1 -> cont=10, tc=1.
- ovf clear collision: force a boundary event with clr_ovf=1 on the same edge -> ovf=1. Next edge clr_ovf=1 with no event -> ovf=0.
- Async reset mid-count: cont=0xAB, ovf=1. Drop rst between edges -> cont=0, tc=0, ovf=0 before the next edge. Release rst with en=1, ud=1 -> cont=1 on the first edge.

Source files
------------

// File: rtl/contador_updown_param.sv
// Bounded up/down counter with runtime limit, wrap/saturate mode, parallel load,
// a one-cycle terminal-count pulse and a sticky overflow flag.
module contador_updown_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cont,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] cont_q, cont_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             bnd_evt;

  always_comb begin
    cont_d  = cont_q;
    bnd_evt = 1'b0;
    if (load) begin
      cont_d = (din <= limit) ? din : limit;
    end else if (en) begin
      if (ud) begin
        // cont >= limit also covers a count left above a freshly lowered limit
        if (cont_q < limit) begin
          cont_d = cont_q + 1'b1;
        end else begin
          bnd_evt = 1'b1;
          cont_d  = sat ? limit : '0;
        end
      end else begin
        if (cont_q == '0) begin
          bnd_evt = 1'b1;
          cont_d  = sat ? '0 : limit;
        end else if (cont_q > limit) begin
          cont_d = limit;
        end else begin
          cont_d = cont_q - 1'b1;
        end
      end
    end
    tc_d  = bnd_evt;
    ovf_d = bnd_evt | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cont_q <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cont_q <= cont_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cont = cont_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;

endmodule
